matrix_pack_tx: RTL and testbench
=================================

// Module: matrix_pack_tx
// PURPOSE
//   Transmit side of the BMM matrix-fill path. Captures one ROWS x COLS matrix of WIDTH-bit
//   elements as a flat word and streams it out one packed row per beat over valid/ready.
//   Concatenating the beats {beat0, beat1, ...} rebuilds the flat word that matrix unpacking
//   consumes, so pack -> unpack round-trips bit-exactly.
// PARAMETERS
//   ROWS   2   matrix rows = beats per matrix (>=1)
//   COLS   4   elements per row
//   WIDTH  4   bits per element
//   CNT_W  8   width of completed-matrix counter
// PORTS
//   clk        in   1                 single clock, rising edge
//   rst_n      in   1                 asynchronous, active-low reset
//   in_mat     in   ROWS*COLS*WIDTH   flat matrix; row 0 in MSBs, within a row col 0 in MSBs
//   in_valid   in   1                 in_mat valid
//   in_ready   out  1                 block can accept a matrix
//   out_data   out  COLS*WIDTH        one packed row, same intra-row order as in_mat
//   out_valid  out  1                 out_data valid
//   out_ready  in   1                 downstream accepts beat
//   out_last   out  1                 high on final row beat of a matrix
//   mat_cnt    out  CNT_W             matrices fully transmitted, wraps at 2^CNT_W
// BEHAVIOUR
//   - Reset (async assert, sync release): state IDLE, in_ready=1, out_valid=0, out_data=0,
//     out_last=0, mat_cnt=0, row index=0, buffer cleared. All outputs are registered.
//   - States: IDLE, SEND.
//   - IDLE: in_ready=1. On in_valid&&in_ready: latch in_mat to buffer, row index=0, go SEND;
//     next cycle out_valid=1, out_data=row 0, in_ready=0. Latency accept->first beat = 1 clk.
//   - SEND: out_data = buffer row[idx]; out_last = (idx==ROWS-1). out_data/out_last held
//     stable while out_valid && !out_ready. On out_valid&&out_ready:
//       idx<ROWS-1: idx++, next row presented the following cycle (no bubble between rows).
//       idx==ROWS-1: out_valid=0, out_last=0, mat_cnt++ (wraps), in_ready=1, go IDLE.
//   - in_valid during SEND is ignored (in_ready=0); upstream must hold. One bubble cycle
//     between matrices: sustained throughput ROWS beats per ROWS+1 clocks.
//   - in_mat changes while in_ready=0 have no effect; buffer only loads on handshake.
//   - ROWS=1: every beat has out_last=1; single handshake returns to IDLE.
//   - mat_cnt at 2^CNT_W-1 wraps to 0 on next completion.
//   - rst_n low mid-matrix: immediately aborts, buffered rows discarded, out_valid drops
//     asynchronously, no partial count.
// CONFIGURATION
//   MATRIX_PACK_PARITY_EN defined: extra port out_parity (out, 1) = even parity (XOR-reduce)
//     of out_data, registered alongside it, reset 0, held stable under backpressure.
//   Undefined: port absent; no other behavioural difference.
// TESTING
//   1 Reset, in_mat=32'h01011101, in_valid 1 clk, out_ready=1 -> beats 16'h0101 (last=0)
//     then 16'h1101 (last=1) on consecutive clks, mat_cnt=1, in_ready back to 1.
//   2 Same stimulus, out_ready low 3 clks on beat 0 -> out_data stays 16'h0101, valid held,
//     then 16'h1101; no beat lost/duplicated.
//   3 Two matrices 32'hABCD1234, 32'h5678EF01 offered back-to-back -> second accepted only
//     after first last beat; beats ABCD,1234,5678,EF01; exactly one bubble; mat_cnt=2.
//   4 rst_n pulsed low after beat 0 of 32'h01011101 -> out_valid=0 at once, mat_cnt=0,
//     in_ready=1; next matrix 32'hFFFF0000 emits FFFF,0000 cleanly.
//   5 CNT_W=2, send 5 matrices -> mat_cnt sequence 1,2,3,0,1.
//   6 With MATRIX_PACK_PARITY_EN, in_mat=32'h01011101 -> out_parity 0 with 16'h0101,
//     1 with 16'h1101; random pack->unpack round-trip compares equal.

Source files
------------

// File: rtl/matrix_pack_tx.sv
// Matrix pack transmitter: captures a ROWS x COLS x WIDTH matrix and streams one packed row per beat.
// Optional MATRIX_PACK_PARITY_EN adds out_parity, the XOR-reduce of out_data registered alongside it.
module matrix_pack_tx #(
  parameter int ROWS  = 2,
  parameter int COLS  = 4,
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ROWS*COLS*WIDTH-1:0]  in_mat,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [COLS*WIDTH-1:0]       out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
`ifdef MATRIX_PACK_PARITY_EN
  output logic                        out_parity,
`endif
  output logic [CNT_W-1:0]            mat_cnt
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high.
  // Valid never waits for ready, and once raised, valid and its data hold until the transfer.

  localparam int ROW_W = COLS * WIDTH;
  localparam int MAT_W = ROWS * ROW_W;
  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]       state_q,     state_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic [MAT_W-1:0] mat_buf_q,   mat_buf_d;
  logic [ROW_W-1:0] out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q,  out_last_d;
  logic             in_ready_q,  in_ready_d;
  logic [CNT_W-1:0] mat_cnt_q,   mat_cnt_d;

  logic             in_fire;
  logic             out_fire;
  logic [IDX_W-1:0] idx_next;

  // Row 0 sits in the MSBs, so shifting left by r rows brings row r to the top.
  function automatic logic [ROW_W-1:0] row_of(input logic [MAT_W-1:0] m,
                                              input logic [IDX_W-1:0] r);
    logic [MAT_W-1:0] sh;
    sh = m << (ROW_W * int'(r));
    return sh[MAT_W-1 -: ROW_W];
  endfunction

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;
  assign idx_next = idx_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mat_buf_d   = mat_buf_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    in_ready_d  = in_ready_q;
    mat_cnt_d   = mat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          mat_buf_d   = in_mat;
          idx_d       = '0;
          out_data_d  = row_of(in_mat, '0);
          out_valid_d = 1'b1;
          out_last_d  = (ROWS == 1);
          in_ready_d  = 1'b0;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_fire) begin
          if (idx_q != LAST_IDX) begin
            idx_d      = idx_next;
            out_data_d = row_of(mat_buf_q, idx_next);
            out_last_d = (idx_next == LAST_IDX);
          end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            in_ready_d  = 1'b1;
            mat_cnt_d   = mat_cnt_q + 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      mat_buf_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      mat_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mat_buf_q   <= mat_buf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      in_ready_q  <= in_ready_d;
      mat_cnt_q   <= mat_cnt_d;
    end
  end

`ifdef MATRIX_PACK_PARITY_EN
  logic parity_q, parity_d;

  // Follows out_data_d, so it changes exactly when out_data does and holds under backpressure.
  always_comb begin
    parity_d = ^out_data_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign out_parity = parity_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign mat_cnt   = mat_cnt_q;

endmodule

// File: tb/tb_matrix_pack_tx.sv
// Bench for matrix_pack_tx (ROWS=2, COLS=4, WIDTH=4, CNT_W=2): directed table, corner sequences,
// and a beat scoreboard; define MATRIX_PACK_PARITY_EN to also check out_parity.
module tb_matrix_pack_tx;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_mat;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [1:0]  mat_cnt;
`ifdef MATRIX_PACK_PARITY_EN
  logic        out_parity;
`endif

  matrix_pack_tx #(.ROWS(2), .COLS(4), .WIDTH(4), .CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_mat    (in_mat),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
`ifdef MATRIX_PACK_PARITY_EN
    .out_parity(out_parity),
`endif
    .mat_cnt   (mat_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [16:0] exp_q[$];
  logic [1:0]  exp_cnt = 2'd0;
  logic        pend = 1'b0;
  logic        rnd_bp = 1'b0;

  typedef struct {
    logic [31:0] mat;
    logic [15:0] r0;
    logic [15:0] r1;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks (entered and left on a negedge) ----------------
  task automatic offer(input logic [31:0] m, input logic [15:0] r0, input logic [15:0] r1);
    logic acc;
    acc = 1'b0;
    exp_q.push_back({1'b0, r0});
    exp_q.push_back({1'b1, r1});
    in_mat   = m;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
      #3;
      acc = in_ready;
      @(negedge clk);
    end
    if (!acc) chk("offer_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_mat   = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (exp_q.size() != 0 || pend); i++) begin
      if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_cnt = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scoreboard / monitor (samples 3 ns after the negedge) ----------------
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("cnt_after_last", mat_cnt, exp_cnt);
          chk("bubble_valid", out_valid, 0);
          chk("bubble_in_ready", in_ready, 1);
          pend = 1'b0;
        end
        if (out_valid) chk("in_ready_low_in_send", in_ready, 0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", {16'd0, out_data}, 32'hFFFFFFFF);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", out_data, e[15:0]);
            chk("beat_last", out_last, e[16]);
`ifdef MATRIX_PACK_PARITY_EN
            chk("beat_parity", out_parity, ^e[15:0]);
`endif
            if (e[16]) begin
              exp_cnt = exp_cnt + 2'd1;
              pend = 1'b1;
            end
          end
        end
      end
    end
  end

  // ---------------- main test ----------------
  initial begin
    logic [31:0] m;
    rst_n     = 1'b0;
    in_mat    = 32'h0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    vecs[0] = '{32'h01011101, 16'h0101, 16'h1101};
    vecs[1] = '{32'hABCD1234, 16'hABCD, 16'h1234};
    vecs[2] = '{32'hDEADBEEF, 16'hDEAD, 16'hBEEF};
    vecs[3] = '{32'h00000000, 16'h0000, 16'h0000};
    vecs[4] = '{32'hFFFF0000, 16'hFFFF, 16'h0000};

    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_mat_cnt", mat_cnt, 0);
`ifdef MATRIX_PACK_PARITY_EN
    chk("rst_parity", out_parity, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: single matrix, latency and first beat
    offer(32'h01011101, 16'h0101, 16'h1101);
    chk("t1_first_valid", out_valid, 1);
    chk("t1_first_data", out_data, 16'h0101);
    chk("t1_first_last", out_last, 0);
    chk("t1_in_ready_low", in_ready, 0);
`ifdef MATRIX_PACK_PARITY_EN
    chk("t6_parity_row0", out_parity, 0);
`endif
    @(negedge clk);
    chk("t1_second_data", out_data, 16'h1101);
    chk("t1_second_last", out_last, 1);
`ifdef MATRIX_PACK_PARITY_EN
    chk("t6_parity_row1", out_parity, 1);
`endif
    drain();
    chk("t1_mat_cnt", mat_cnt, 1);
    chk("t1_in_ready_back", in_ready, 1);

    // Test 2: backpressure on beat 0 for 3 clocks
    out_ready = 1'b0;
    offer(32'h01011101, 16'h0101, 16'h1101);
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_valid", out_valid, 1);
      chk("t2_hold_data", out_data, 16'h0101);
      chk("t2_hold_last", out_last, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    drain();
    chk("t2_mat_cnt", mat_cnt, 2);

    // Test 3: two matrices offered back to back from a fresh reset
    do_reset();
    offer(32'hABCD1234, 16'hABCD, 16'h1234);
    offer(32'h5678EF01, 16'h5678, 16'hEF01);
    drain();
    chk("t3_mat_cnt", mat_cnt, 2);

    // Directed table
    for (int i = 0; i < 5; i++) begin
      offer(vecs[i].mat, vecs[i].r0, vecs[i].r1);
      drain();
    end

    // Test 5: counter wrap with CNT_W=2 (sequence 1,2,3,0,1 checked by the scoreboard)
    do_reset();
    for (int i = 0; i < 5; i++) begin
      offer(32'h12345678 + i, 16'h1234, 16'h5678 + 16'(i));
    end
    drain();
    chk("t5_mat_cnt_final", mat_cnt, 1);

    // Test 4: reset mid-matrix after beat 0
    do_reset();
    offer(32'h01011101, 16'h0101, 16'h1101);
    @(negedge clk);
    chk("t4_beat1_shown", out_data, 16'h1101);
    #2;
    exp_q.delete();
    exp_cnt = 2'd0;
    rst_n = 1'b0;
    #1;
    chk("t4_async_valid", out_valid, 0);
    chk("t4_async_last", out_last, 0);
    chk("t4_async_in_ready", in_ready, 1);
    chk("t4_async_cnt", mat_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    offer(32'hFFFF0000, 16'hFFFF, 16'h0000);
    drain();
    chk("t4_cnt_after", mat_cnt, 1);

    // Random round trip with random backpressure
    rnd_bp = 1'b1;
    for (int i = 0; i < 10; i++) begin
      m = $urandom;
      offer(m, m[31:16], m[15:0]);
    end
    drain();
    rnd_bp = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
